// File: rtl/mul_result_uart_tx.sv
`timescale 1ns/1ps
// mul_result_uart_tx
// Sends the shift-add multiplier's 2N-bit product back to the host as UART
// 8N1 frames, most-significant byte first. A transmission starts on each
// rising edge of finish_in that arrives while idle. The product is captured
// on that edge, so later input changes do not affect the frame in flight.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   finish_in  multiplier finish flag (level)
//   product_in multiplier product, valid while finish_in is high
//   tx         UART serial output, idle high
//   busy       high while a result is being transmitted
//   done       one-cycle pulse when the last stop bit of a result completes
//   overrun    sticky: a finish edge arrived while not idle
module mul_result_uart_tx #(
   parameter int unsigned N            = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           finish_in,
   input  logic [2*N-1:0] product_in,
   output logic           tx,
   output logic           busy,
   output logic           done,
   output logic           overrun
);

   localparam int unsigned PW = 2 * N;
   localparam int unsigned NB = PW / 8;
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BYTE_LAST = IW'(NB - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    state;
   logic          finish_prev;
   logic [PW-1:0] shreg;
   logic [IW-1:0] byte_idx;
   logic [2:0]    bit_idx;
   logic [BW-1:0] baud_cnt;

   logic          edge_det;
   logic          baud_end;
   logic [7:0]    cur_byte;

   assign edge_det = finish_in & ~finish_prev;
   assign baud_end = (baud_cnt == BAUD_LAST);
   // The byte being sent always sits in the top 8 bits; the register shifts
   // left by one byte after each stop bit.
   assign cur_byte = shreg[PW-1 -: 8];

   // tx is registered and updated on the same edge as the state change, so
   // each level is held for exactly CLKS_PER_BIT cycles with no glitches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         finish_prev <= 1'b1;
         shreg       <= '0;
         byte_idx    <= '0;
         bit_idx     <= '0;
         baud_cnt    <= '0;
         tx          <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         finish_prev <= finish_in;
         done        <= 1'b0;

         if (edge_det && (state != S_IDLE)) begin
            overrun <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (edge_det) begin
                  shreg    <= product_in;
                  byte_idx <= '0;
                  baud_cnt <= '0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_START;
               end
            end

            S_START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= cur_byte[0];
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            S_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            S_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (byte_idx != BYTE_LAST) begin
                     byte_idx <= byte_idx + IW'(1);
                     shreg    <= shreg << 8;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_result_uart_tx.sv
`timescale 1ns/1ps
// Testbench for mul_result_uart_tx: a fast-baud instance (4 clocks/bit)
// exercised by directed results, with a UART-decoding monitor checking frames
// against a queue of expected bytes, plus an 868 clocks/bit bit-period check.
module tb_mul_result_uart_tx;

   localparam int C = 4;

   typedef struct {
      logic [7:0] data;
      bit         last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        finish = 1'b0;
   logic [15:0] product = '0;
   logic        tx, busy, done, overrun;

   logic        fin_b = 1'b0;
   logic [15:0] prod_b = '0;
   logic        tx_b, busy_b, done_b, ovr_b;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   done_cnt = 0;

   mul_result_uart_tx #(.N(8), .CLKS_PER_BIT(C)) u_dut (
      .clk(clk), .reset(reset), .finish_in(finish), .product_in(product),
      .tx(tx), .busy(busy), .done(done), .overrun(overrun)
   );

   mul_result_uart_tx #(.N(8), .CLKS_PER_BIT(868)) u_big (
      .clk(clk), .reset(reset), .finish_in(fin_b), .product_in(prod_b),
      .tx(tx_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, expv);
      end
   endfunction

   // Decode one frame; the caller is at the negedge holding the first
   // start-bit sample. Every sample of a bit must match its first sample.
   task automatic rx_frame(output logic [7:0] data, output bit ok, output bit aborted);
      logic [9:0] lv;
      ok = 1'b1;
      aborted = 1'b0;
      lv = '0;
      data = '0;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (reset !== 1'b1) begin
               aborted = 1'b1;
               return;
            end
            if (c == 0) lv[b] = tx;
            else if (tx !== lv[b]) ok = 1'b0;
         end
      end
      data = lv[8:1];
      if (lv[0] !== 1'b0 || lv[9] !== 1'b1) ok = 1'b0;
   endtask

   initial begin : done_counter
      forever begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
   end

   initial begin : monitor
      logic [7:0] d;
      bit ok, ab, last;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && tx === 1'b0) begin
            last = 1'b0;
            while (!last) begin
               rx_frame(d, ok, ab);
               if (ab) break;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frame: got byte %02h, required no frame", d);
                  last = 1'b1;
               end else begin
                  e = exp_q.pop_front();
                  check("frame_bits", 32'(ok), 32'd1);
                  check("frame_byte", 32'(d), 32'(e.data));
                  last = e.last;
                  @(negedge clk);
                  if (reset !== 1'b1) break;
                  if (!last) begin
                     check("gap_tx", 32'(tx), 32'd0);
                     check("gap_busy", 32'(busy), 32'd1);
                  end else begin
                     check("end_busy", 32'(busy), 32'd0);
                     check("end_done", 32'(done), 32'd1);
                  end
               end
            end
         end
      end
   end

   // One result on the fast instance; optional second finish edge at ovr_at.
   task automatic run_result(input logic [15:0] p, input int ovr_at);
      int cnt;
      int d0;
      exp_t e;
      finish = 1'b0;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      product = p;
      finish = 1'b1;
      e.data = p[15:8]; e.last = 1'b0; exp_q.push_back(e);
      e.data = p[7:0];  e.last = 1'b1; exp_q.push_back(e);
      @(negedge clk);
      check("latency_tx", 32'(tx), 32'd0);
      check("latency_busy", 32'(busy), 32'd1);
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         if (ovr_at != 0 && cnt == 10) finish = 1'b0;
         if (ovr_at != 0 && cnt == ovr_at) begin
            product = 16'h1234;
            finish = 1'b1;
         end
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(cnt), 32'd80);
      @(negedge clk);
      check("done_pulses", 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int d0;
      int n;
      exp_t e;

      repeat (2) @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_big_tx", 32'(tx_b), 32'd1);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      run_result(16'hA53C, 0);
      run_result(16'hFFFF, 0);
      run_result(16'h0000, 0);
      check("no_overrun", 32'(overrun), 32'd0);

      run_result(16'hA53C, 30);
      check("overrun_set", 32'(overrun), 32'd1);
      repeat (100) @(negedge clk);
      check("no_second_result", 32'(busy), 32'd0);
      check("overrun_sticky", 32'(overrun), 32'd1);

      // reset during byte 0 data bits
      finish = 1'b0;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      product = 16'hA53C;
      finish = 1'b1;
      e.data = 8'hA5; e.last = 1'b0; exp_q.push_back(e);
      e.data = 8'h3C; e.last = 1'b1; exp_q.push_back(e);
      repeat (12) @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("async_rst_tx", 32'(tx), 32'd1);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_overrun", 32'(overrun), 32'd0);
      repeat (3) @(negedge clk);
      exp_q.delete();
      finish = 1'b0;
      reset = 1'b1;
      repeat (50) @(negedge clk);
      check("post_reset_idle_busy", 32'(busy), 32'd0);
      check("post_reset_idle_tx", 32'(tx), 32'd1);
      check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);

      // finish held high through reset release
      reset = 1'b0;
      finish = 1'b1;
      product = 16'h1234;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("held_finish_busy", 32'(busy), 32'd0);
      check("held_finish_tx", 32'(tx), 32'd1);
      run_result(16'h1234, 0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      // 868 clocks/bit: start-bit length of both bytes
      prod_b = 16'h5501;
      repeat (2) @(negedge clk);
      fin_b = 1'b1;
      @(negedge clk);
      check("big_start_tx", 32'(tx_b), 32'd0);
      n = 0;
      while (tx_b === 1'b0 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("big_start0_len", 32'(n), 32'd868);
      repeat (8679 - 868) @(negedge clk);
      check("big_stop0_tx", 32'(tx_b), 32'd1);
      @(negedge clk);
      check("big_start1_tx", 32'(tx_b), 32'd0);
      n = 0;
      while (tx_b === 1'b0 && n < 2000) begin
         n++;
         @(negedge clk);
      end
      check("big_start1_len", 32'(n), 32'd868);
      repeat (17359 - 9548) @(negedge clk);
      check("big_busy_last", 32'(busy_b), 32'd1);
      @(negedge clk);
      check("big_busy_end", 32'(busy_b), 32'd0);
      check("big_done", 32'(done_b), 32'd1);
      check("big_overrun", 32'(ovr_b), 32'd0);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
